// File: rtl/alu_rx_sequencer.sv
// Sequences the ALU from a received byte stream: A, B, op in; result out as two bytes, MSB first.
// Every output is registered, so o_tx_valid/o_tx_data never depend combinationally on i_tx_ready.
module alu_rx_sequencer #(
  parameter int NB_OP   = 6,
  parameter int NB_DATA = 8,
  parameter int NB_OUT  = 2*NB_DATA
) (
  input  logic               i_clk,
  input  logic               i_reset,
  input  logic [NB_DATA-1:0] i_rx_data,
  input  logic               i_rx_valid,
  output logic [NB_DATA-1:0] o_alu_data_a,
  output logic [NB_DATA-1:0] o_alu_data_b,
  output logic [NB_OP-1:0]   o_alu_op,
  input  logic [NB_OUT-1:0]  i_alu_result,
  output logic [NB_DATA-1:0] o_tx_data,
  output logic               o_tx_valid,
  input  logic               i_tx_ready,
  output logic               o_busy,
  output logic               o_done,
  output logic               o_overrun
);

  typedef enum logic [2:0] {WAIT_A, WAIT_B, WAIT_OP, EXEC, SEND_HI, SEND_LO} state_t;

  state_t               state_q, state_d;
  logic [NB_DATA-1:0]   a_q, a_d, b_q, b_d, tx_data_q, tx_data_d;
  logic [NB_OP-1:0]     op_q, op_d;
  logic [NB_OUT-1:0]    result_q, result_d;
  logic                 tx_valid_q, tx_valid_d, busy_q, busy_d;
  logic                 done_q, done_d, overrun_q, overrun_d;
  logic                 in_busy_st;

  assign in_busy_st = (state_q == EXEC) || (state_q == SEND_HI) || (state_q == SEND_LO);

  always_ff @(posedge i_clk) begin
    if (!i_reset) state_q <= WAIT_A;
    else          state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      WAIT_A:  if (i_rx_valid) state_d = WAIT_B;
      WAIT_B:  if (i_rx_valid) state_d = WAIT_OP;
      WAIT_OP: if (i_rx_valid) state_d = EXEC;
      EXEC:    state_d = SEND_HI;
      SEND_HI: if (i_tx_ready) state_d = SEND_LO;
      SEND_LO: if (i_tx_ready) state_d = WAIT_A;
      default: state_d = WAIT_A;
    endcase
  end

  // Outputs are decoded from the next state so they line up with the registered state.
  always_comb begin
    a_d      = a_q;
    b_d      = b_q;
    op_d     = op_q;
    result_d = result_q;
    if (i_rx_valid) begin
      case (state_q)
        WAIT_A:  a_d  = i_rx_data;
        WAIT_B:  b_d  = i_rx_data;
        WAIT_OP: op_d = i_rx_data[NB_OP-1:0];
        default: ;
      endcase
    end
    if (state_q == EXEC) result_d = i_alu_result;
    tx_valid_d = (state_d == SEND_HI) || (state_d == SEND_LO);
    busy_d     = tx_valid_d || (state_d == EXEC);
    tx_data_d  = tx_data_q;
    if (state_d == SEND_HI)      tx_data_d = result_d[NB_OUT-1:NB_DATA];
    else if (state_d == SEND_LO) tx_data_d = result_d[NB_DATA-1:0];
    done_d    = (state_q == SEND_LO) && i_tx_ready;
    overrun_d = i_rx_valid && in_busy_st;
  end

  always_ff @(posedge i_clk) begin
    if (!i_reset) begin
      a_q        <= '0;
      b_q        <= '0;
      op_q       <= '0;
      result_q   <= '0;
      tx_data_q  <= '0;
      tx_valid_q <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      overrun_q  <= 1'b0;
    end else begin
      a_q        <= a_d;
      b_q        <= b_d;
      op_q       <= op_d;
      result_q   <= result_d;
      tx_data_q  <= tx_data_d;
      tx_valid_q <= tx_valid_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
      overrun_q  <= overrun_d;
    end
  end

  assign o_alu_data_a = a_q;
  assign o_alu_data_b = b_q;
  assign o_alu_op     = op_q;
  assign o_tx_data    = tx_data_q;
  assign o_tx_valid   = tx_valid_q;
  assign o_busy       = busy_q;
  assign o_done       = done_q;
  assign o_overrun    = overrun_q;

endmodule

// File: tb/tb_alu_rx_sequencer.sv
// Transaction-level bench: expected tx bytes come from the bytes sent and an ALU function.
module tb_alu_rx_sequencer;
  logic        clk = 1'b0;
  logic        rst_n;
  logic [7:0]  rx_data;
  logic        rx_valid;
  logic [7:0]  alu_a, alu_b, tx_data;
  logic [5:0]  alu_op;
  logic [15:0] alu_res;
  logic        tx_valid, tx_ready, busy, done, overrun;

  int n_chk = 0, n_pass = 0;
  int alu_mode = 0;
  int ovr_cnt = 0, done_cnt = 0, n_txn = 0;

  always #5 clk = ~clk;

  alu_rx_sequencer dut (
    .i_clk(clk), .i_reset(rst_n),
    .i_rx_data(rx_data), .i_rx_valid(rx_valid),
    .o_alu_data_a(alu_a), .o_alu_data_b(alu_b), .o_alu_op(alu_op),
    .i_alu_result(alu_res),
    .o_tx_data(tx_data), .o_tx_valid(tx_valid), .i_tx_ready(tx_ready),
    .o_busy(busy), .o_done(done), .o_overrun(overrun)
  );

  function automatic logic [15:0] alu_f(int m, logic [7:0] a, logic [7:0] b, logic [5:0] op);
    case (m)
      0:       return {8'h00, a} + {8'h00, b};
      1:       return 16'hABCD;
      default: return {a ^ {2'b00, op}, b - a};
    endcase
  endfunction

  assign alu_res = alu_f(alu_mode, alu_a, alu_b, alu_op);

  always @(negedge clk) begin
    ovr_cnt  += int'(overrun);
    done_cnt += int'(done);
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask

  // tx_ready is randomised while waiting for bytes: it must be ignored there.
  task automatic rx(input logic [7:0] d);
    rx_data  = d;
    rx_valid = 1'b1;
    tx_ready = 1'($urandom_range(0, 1));
    step();
    rx_valid = 1'b0;
    tx_ready = 1'b0;
  endtask

  task automatic txn(input logic [7:0] a, input logic [7:0] b, input logic [7:0] opb,
                     input int shi, input int slo, input bit ovr);
    logic [15:0] exp;
    int ov0;
    exp = alu_f(alu_mode, a, b, opb[5:0]);
    ov0 = ovr_cnt;
    rx(a);   chk("opA", alu_a, a);
    rx(b);   chk("opB", alu_b, b);
    rx(opb); chk("op", alu_op, opb[5:0]);
    chk("busyExec", busy, 1);
    chk("vldExec", tx_valid, 0);
    step();
    for (int i = 0; i <= shi; i++) begin
      chk("hiValid", tx_valid, 1);
      chk("hiByte", tx_data, exp[15:8]);
      if (ovr && i == 0) begin rx_data = 8'h7F; rx_valid = 1'b1; end
      tx_ready = (i == shi);
      step();
      rx_valid = 1'b0;
    end
    for (int i = 0; i <= slo; i++) begin
      chk("loValid", tx_valid, 1);
      chk("loByte", tx_data, exp[7:0]);
      tx_ready = (i == slo);
      step();
    end
    tx_ready = 1'b0;
    n_txn++;
    chk("done", done, 1);
    chk("busyEnd", busy, 0);
    chk("vldEnd", tx_valid, 0);
    chk("ovrCount", ovr_cnt - ov0, ovr ? 1 : 0);
    chk("keepA", alu_a, a);
    chk("keepB", alu_b, b);
    chk("keepOp", alu_op, opb[5:0]);
  endtask

  initial begin
    rst_n = 1'b0; rx_data = '0; rx_valid = 1'b0; tx_ready = 1'b0;
    @(negedge clk);
    step(); step();
    chk("rstA", alu_a, 0);   chk("rstOp", alu_op, 0);
    chk("rstVld", tx_valid, 0); chk("rstBusy", busy, 0);
    rst_n = 1'b1;

    alu_mode = 0; txn(8'h05, 8'h03, 8'h20, 0, 0, 0);
    txn(8'h05, 8'h03, 8'h20, 5, 0, 0);
    txn(8'h05, 8'h03, 8'h20, 0, 1, 1);
    alu_mode = 1; txn(8'hFF, 8'hFF, 8'h3F, 0, 0, 0);
    alu_mode = 2; txn(8'h12, 8'h9A, 8'hC5, 0, 0, 0);
    txn(8'h77, 8'h01, 8'h0E, 0, 0, 0);

    // Reset in the middle of SEND_LO.
    alu_mode = 0;
    rx(8'h12); rx(8'h34); rx(8'h20); step();
    tx_ready = 1'b1; step(); tx_ready = 1'b0;
    chk("preRstLo", tx_data, 8'h46);
    rst_n = 1'b0; step(); step(); rst_n = 1'b1;
    chk("midRstA", alu_a, 0);     chk("midRstB", alu_b, 0);
    chk("midRstOp", alu_op, 0);   chk("midRstTx", tx_data, 0);
    chk("midRstVld", tx_valid, 0); chk("midRstBusy", busy, 0);
    chk("midRstDone", done, 0);   chk("midRstOvr", overrun, 0);
    rx(8'h11);
    chk("postRstA", alu_a, 8'h11);
    chk("postRstB", alu_b, 0);
    chk("postRstBusy", busy, 0);
    rst_n = 1'b0; step(); rst_n = 1'b1;

    for (int t = 0; t < 40; t++) begin
      alu_mode = int'($urandom_range(0, 2));
      txn(8'($urandom), 8'($urandom), 8'($urandom),
          int'($urandom_range(0, 3)), int'($urandom_range(0, 3)), 1'($urandom_range(0, 1)));
    end

    step();
    chk("doneTotal", done_cnt, n_txn);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
